// File: rtl/sid_spi_decoder.sv
// SID SPI byte-stream decoder: header/data framing, per-channel write FIFO.
// Optional macro SID_DEC_PACE_EN paces FIFO pops to the SID 1 MHz enable.
module sid_spi_decoder #(
   parameter int NUM_CH     = 2,
   parameter int FIFO_DEPTH = 16,
   parameter int TIMEOUT    = 4095,
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int PTR_W = $clog2(FIFO_DEPTH),
   localparam int LVL_W = PTR_W + 1,
   localparam int TO_W  = $clog2(TIMEOUT + 1),
   localparam int E_W   = CH_W + 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        iByte,
   input  logic              iByteValid,
   input  logic              iClkEn,
   input  logic              iClrOvf,
   output logic [NUM_CH-1:0] oWE,
   output logic [4:0]        oAddr,
   output logic [7:0]        oData,
   output logic [LVL_W-1:0]  oLevel,
   output logic              oOverflow
);

   typedef enum logic {IDLE, HDR} state_t;

   state_t           state;
   logic [4:0]       hdr_addr;
   logic [1:0]       hdr_dd;
   logic [TO_W-1:0]  idle_cnt;
   logic [CH_W-1:0]  cur_ch;
   logic             push_vld;
   logic [E_W-1:0]   push_ent;

   logic [E_W-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [E_W-1:0]   rd_ent;
   logic             full;
   logic             empty;
   logic             pop;
   logic             push_ok;
   logic             drop;

   assign full    = (oLevel == LVL_W'(FIFO_DEPTH));
   assign empty   = (oLevel == '0);
   assign push_ok = push_vld && (!full || pop);
   assign drop    = push_vld && full && !pop;
   assign rd_ent  = mem[rd_ptr];

`ifdef SID_DEC_PACE_EN
   assign pop = !empty && iClkEn;
`else
   logic clk_en_unused;
   assign clk_en_unused = iClkEn;
   assign pop = !empty;
`endif

   // Frame decoder: header capture, data completion, idle timeout, channel select
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         hdr_addr <= '0;
         hdr_dd   <= '0;
         idle_cnt <= '0;
         cur_ch   <= '0;
         push_vld <= 1'b0;
         push_ent <= '0;
      end else begin
         push_vld <= 1'b0;
         unique case (state)
            IDLE: begin
               if (iByteValid && iByte[7]) begin
                  hdr_addr <= iByte[6:2];
                  hdr_dd   <= iByte[1:0];
                  idle_cnt <= '0;
                  state    <= HDR;
               end
            end
            HDR: begin
               if (iByteValid) begin
                  idle_cnt <= '0;
                  if (iByte[7]) begin
                     hdr_addr <= iByte[6:2];
                     hdr_dd   <= iByte[1:0];
                  end else begin
                     state <= IDLE;
                     // select frame uses the data byte payload only
                     if (hdr_addr == 5'h1F) begin
                        if (iByte[5:0] < 6'(NUM_CH))
                           cur_ch <= iByte[CH_W-1:0];
                     end else begin
                        push_vld <= 1'b1;
                        push_ent <= {cur_ch, hdr_addr, hdr_dd, iByte[5:0]};
                     end
                  end
               end else if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
                  idle_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  idle_cnt <= idle_cnt + TO_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO storage; contents need no reset since pointers define validity
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_ent;
   end

   // FIFO pointers, occupancy, sticky overflow and registered write port
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         oLevel    <= '0;
         oOverflow <= 1'b0;
         oWE       <= '0;
         oAddr     <= '0;
         oData     <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_ok && !pop)
            oLevel <= oLevel + LVL_W'(1);
         else if (pop && !push_ok)
            oLevel <= oLevel - LVL_W'(1);
         if (drop)
            oOverflow <= 1'b1;
         else if (iClrOvf)
            oOverflow <= 1'b0;
         oWE <= '0;
         if (pop) begin
            oWE   <= NUM_CH'(1) << rd_ent[E_W-1 -: CH_W];
            oAddr <= rd_ent[12:8];
            oData <= rd_ent[7:0];
         end
      end
   end

endmodule

// File: tb/tb_sid_spi_decoder.sv
// Bench for sid_spi_decoder: queue-based behavioural model checked every
// cycle, plus literal expectations on hand-worked frames.
module tb_sid_spi_decoder;

   localparam int NCH   = 2;
   localparam int DEPTH = 16;
   localparam int TO    = 50;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] iByte = 8'h00;
   logic       iByteValid = 1'b0;
   logic       iClkEn = 1'b1;
   logic       iClrOvf = 1'b0;
   logic [NCH-1:0] oWE;
   logic [4:0] oAddr;
   logic [7:0] oData;
   logic [4:0] oLevel;
   logic       oOverflow;

   int checks = 0;
   int errs = 0;

   always #5 clk = ~clk;

   sid_spi_decoder #(
      .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .iByte(iByte), .iByteValid(iByteValid),
      .iClkEn(iClkEn), .iClrOvf(iClrOvf), .oWE(oWE), .oAddr(oAddr),
      .oData(oData), .oLevel(oLevel), .oOverflow(oOverflow)
   );

   typedef struct packed {
      logic [7:0] ch;
      logic [4:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t        q[$];
   wr_t        pend;
   wr_t        m_e;
   bit         pend_v = 0;
   bit         hdr_v = 0;
   logic [4:0] hdr_a;
   logic [1:0] hdr_dd;
   int         idle = 0;
   int         cur = 0;
   int         sz;
   bit         pop;
   bit         drop;
   bit         armed = 0;
   logic [NCH-1:0] m_we = '0;
   logic [4:0] m_addr = '0;
   logic [7:0] m_data = '0;
   bit         m_ovf = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
      end
   endtask

   // behavioural model: frames by rule, FIFO as a queue
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         pend_v = 0; hdr_v = 0; idle = 0; cur = 0;
         m_we = '0; m_addr = '0; m_data = '0; m_ovf = 0;
         armed = 1;
      end else begin
         sz = q.size();
         pop = (sz > 0);
`ifdef SID_DEC_PACE_EN
         pop = pop && iClkEn;
`endif
         m_we = '0;
         if (pop) begin
            m_e = q.pop_front();
            m_we = NCH'(1) << m_e.ch;
            m_addr = m_e.a;
            m_data = m_e.d;
         end
         drop = 0;
         if (pend_v) begin
            if (sz < DEPTH || pop) q.push_back(pend);
            else drop = 1;
         end
         if (drop) m_ovf = 1;
         else if (iClrOvf) m_ovf = 0;
         pend_v = 0;
         if (iByteValid) begin
            idle = 0;
            if (iByte[7]) begin
               hdr_v = 1; hdr_a = iByte[6:2]; hdr_dd = iByte[1:0];
            end else if (hdr_v) begin
               hdr_v = 0;
               if (hdr_a == 5'h1F) begin
                  if (int'(iByte[5:0]) < NCH) cur = int'(iByte[5:0]);
               end else begin
                  pend = '{ch: 8'(cur), a: hdr_a, d: {hdr_dd, iByte[5:0]}};
                  pend_v = 1;
               end
            end
         end else if (hdr_v) begin
            idle++;
            if (idle == TO) hdr_v = 0;
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (armed) begin
         chk("we", 32'(oWE), 32'(m_we));
         chk("addr", 32'(oAddr), 32'(m_addr));
         chk("data", 32'(oData), 32'(m_data));
         chk("level", 32'(oLevel), 32'(q.size()));
         chk("ovf", 32'(oOverflow), 32'(m_ovf));
      end
   end

   task automatic send(input logic [7:0] b);
      iByte = b;
      iByteValid = 1'b1;
      @(negedge clk);
      iByteValid = 1'b0;
   endtask

   task automatic wait_cy(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [7:0] h;
   logic [7:0] d;

   initial begin
      wait_cy(3);
      chk("lit_rst_we", 32'(oWE), 0);
      chk("lit_rst_level", 32'(oLevel), 0);
      chk("lit_rst_ovf", 32'(oOverflow), 0);
      rst = 1'b0;

      send(8'h86); send(8'h15);
      wait_cy(1);
      chk("lit_f1_level", 32'(oLevel), 1);
      wait_cy(1);
      chk("lit_f1_we", 32'(oWE), 32'h1);
      chk("lit_f1_addr", 32'(oAddr), 32'h01);
      chk("lit_f1_data", 32'(oData), 32'h95);
      wait_cy(1);
      chk("lit_f1_we_off", 32'(oWE), 0);
      chk("lit_f1_hold", 32'(oData), 32'h95);

      send(8'hFE); send(8'h01);
      send(8'h80); send(8'h3F);
      wait_cy(2);
      chk("lit_f2_we", 32'(oWE), 32'h2);
      chk("lit_f2_addr", 32'(oAddr), 32'h00);
      chk("lit_f2_data", 32'(oData), 32'h3F);
      send(8'hFE); send(8'h05);
      send(8'h80); send(8'h21);
      wait_cy(2);
      chk("lit_f3_we", 32'(oWE), 32'h2);

      send(8'h84); wait_cy(TO); send(8'h10);
      wait_cy(1);
      chk("lit_to_level", 32'(oLevel), 0);
      wait_cy(1);
      chk("lit_to_we", 32'(oWE), 0);
      send(8'h84); wait_cy(TO - 1); send(8'h10);
      wait_cy(2);
      chk("lit_to1_we", 32'(oWE), 32'h2);
      chk("lit_to1_data", 32'(oData), 32'h10);
      send(8'h84); wait_cy(TO - 1);
      send(8'h84); wait_cy(TO - 1); send(8'h11);
      wait_cy(3);

      send(8'hFE); send(8'h00);
      send(8'h88); send(8'h8B); send(8'h02);
      wait_cy(2);
      chk("lit_rep_we", 32'(oWE), 32'h1);
      chk("lit_rep_addr", 32'(oAddr), 32'h02);
      chk("lit_rep_data", 32'(oData), 32'hC2);

      send(8'hFE); send(8'h01);
      send(8'h86);
      rst = 1'b1; wait_cy(1); rst = 1'b0;
      send(8'h15);
      wait_cy(2);
      chk("lit_rstm_level", 32'(oLevel), 0);
      chk("lit_rstm_we", 32'(oWE), 0);
      send(8'h86); send(8'h15);
      wait_cy(2);
      chk("lit_rstch_we", 32'(oWE), 32'h1);
      send(8'h86); send(8'h15);
      rst = 1'b1; wait_cy(1); rst = 1'b0;
      chk("lit_rstp_level", 32'(oLevel), 0);
      wait_cy(1);
      chk("lit_rstp_we", 32'(oWE), 0);

      for (int i = 0; i < 40; i++) begin
         iClkEn = 1'(i % 2);
         if (i % 10 == 5) begin
            send(8'hFC); send({2'b00, 6'(i % 3)});
         end
         h = {1'b1, 5'(i % 31), 2'(i % 4)};
         d = {2'b00, 6'((i * 7) % 64)};
         send(h); send(d);
      end
      iClkEn = 1'b1;
      wait_cy(40);
      chk("lit_wrap_level", 32'(oLevel), 0);

`ifdef SID_DEC_PACE_EN
      iClkEn = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         send({1'b1, 5'(i), 2'(i % 4)});
         send({2'b00, 6'(i + 3)});
      end
      wait_cy(2);
      chk("lit_full_level", 32'(oLevel), DEPTH);
      chk("lit_full_ovf", 32'(oOverflow), 1);
      iClrOvf = 1'b1; wait_cy(1); iClrOvf = 1'b0;
      chk("lit_clr_ovf", 32'(oOverflow), 0);
      iClrOvf = 1'b1;
      send(8'h90); send(8'h01);
      wait_cy(1);
      iClrOvf = 1'b0;
      chk("lit_dropclr_ovf", 32'(oOverflow), 1);
      iClrOvf = 1'b1; wait_cy(1); iClrOvf = 1'b0;
      send(8'h94); send(8'h2A);
      iClkEn = 1'b1; wait_cy(1); iClkEn = 1'b0;
      chk("lit_pp_level", 32'(oLevel), DEPTH);
      chk("lit_pp_ovf", 32'(oOverflow), 0);
      for (int i = 0; i < DEPTH * 12 + 12; i++) begin
         iClkEn = (i % 12 == 0);
         wait_cy(1);
      end
      chk("lit_drain_level", 32'(oLevel), 0);
      iClkEn = 1'b1;
`endif

      wait_cy(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errs);
      $finish;
   end

endmodule
